// File: rtl/shift_unit_if.sv
// rtl/shift_unit_if.sv - request/result handshake bundle for the pipelined shifter
interface shift_unit_if #(
  parameter int WIDTH   = 24,
  parameter int SHAMT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [2:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_carry;
  logic               out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - two-stage SLL/SRL/SRA/ROL/ROR barrel shifter with carry and zero flags
module shift_unit #(
  parameter int WIDTH   = 24,
  parameter int SHAMT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  shift_unit_if.slave bus
);
  localparam int RW = $clog2(WIDTH);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_data_q, s1_data_d;
  logic [2:0]         s1_op_q, s1_op_d;
  logic [SHAMT_W-1:0] s1_shamt_q, s1_shamt_d;
  logic [RW-1:0]      s1_rot_q, s1_rot_d;
  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]   s2_data_q, s2_data_d;
  logic               s2_carry_q, s2_carry_d;
  logic               s2_zero_q, s2_zero_d;

  logic               s2_load;
  logic               in_ready;
  logic [31:0]        k;
  logic               k_in_range;
  logic [2*WIDTH-1:0] left_w;
  logic [2*WIDTH-1:0] right_w;
  logic [2*WIDTH-1:0] sra_w;
  logic [WIDTH-1:0]   rol_v;
  logic [WIDTH-1:0]   ror_v;
  logic [WIDTH-1:0]   res;
  logic               carry;

  // Shifting the operand into a double-width window leaves the last bit shifted
  // out sitting just beyond the result field, which is exactly the carry.
  always_comb begin
    k          = 32'(s1_shamt_q);
    k_in_range = (k != 32'd0) && (k <= 32'(WIDTH));
    left_w     = {{WIDTH{1'b0}}, s1_data_q} << k;
    right_w    = {s1_data_q, {WIDTH{1'b0}}} >> k;
    sra_w      = $unsigned($signed({s1_data_q, {WIDTH{1'b0}}}) >>> k);
    rol_v      = (s1_data_q << s1_rot_q) | (s1_data_q >> (32'(WIDTH) - 32'(s1_rot_q)));
    ror_v      = (s1_data_q >> s1_rot_q) | (s1_data_q << (32'(WIDTH) - 32'(s1_rot_q)));
    res        = '0;
    carry      = 1'b0;
    case (s1_op_q)
      OP_SLL: begin
        res   = left_w[WIDTH-1:0];
        carry = k_in_range & left_w[WIDTH];
      end
      OP_SRL: begin
        res   = right_w[2*WIDTH-1:WIDTH];
        carry = k_in_range & right_w[WIDTH-1];
      end
      OP_SRA: begin
        res   = sra_w[2*WIDTH-1:WIDTH];
        carry = (k != 32'd0) & sra_w[WIDTH-1];
      end
      OP_ROL:  res = rol_v;
      OP_ROR:  res = ror_v;
      default: res = '0;
    endcase
  end

  always_comb begin
    s2_load    = !s2_valid_q || bus.out_ready;
    in_ready   = !s1_valid_q || s2_load;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_op_d    = s1_op_q;
    s1_shamt_d = s1_shamt_q;
    s1_rot_d   = s1_rot_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_carry_d = s2_carry_q;
    s2_zero_d  = s2_zero_q;
    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_data_d  = bus.in_data;
        s1_op_d    = bus.in_op;
        s1_shamt_d = bus.in_shamt;
        s1_rot_d   = RW'(32'(bus.in_shamt) % 32'(WIDTH));
      end
    end
    // Result registers only change when a real request moves in, so a drained
    // pipeline keeps presenting its last value instead of toggling.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d  = res;
        s2_carry_d = carry;
        s2_zero_d  = (res == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_op_q    <= '0;
      s1_shamt_q <= '0;
      s1_rot_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_carry_q <= 1'b0;
      s2_zero_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_op_q    <= s1_op_d;
      s1_shamt_q <= s1_shamt_d;
      s1_rot_q   <= s1_rot_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_carry_q <= s2_carry_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_carry = s2_carry_q;
  assign bus.out_zero  = s2_zero_q;
endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - directed and randomized checks of shift_unit against a bit-serial model
module tb_shift_unit;
  localparam int W  = 24;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  int   n_out      = 0;

  logic [W+1:0] exp_q[$];
  logic         stall_prev = 1'b0;
  logic [W+1:0] held;

  always #5 clk = ~clk;

  shift_unit_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // One single-bit step at a time: the carry is simply the last bit that fell off.
  function automatic logic [W+1:0] model(input logic [2:0] op, input logic [W-1:0] d, input int k);
    logic [W-1:0] v;
    logic         c;
    v = d;
    c = 1'b0;
    case (op)
      3'd0: repeat (k) begin c = v[W-1]; v = {v[W-2:0], 1'b0}; end
      3'd1: repeat (k) begin c = v[0]; v = {1'b0, v[W-1:1]}; end
      3'd2: repeat (k) begin c = v[0]; v = {v[W-1], v[W-1:1]}; end
      3'd3: repeat (k % W) v = {v[W-2:0], v[W-1]};
      3'd4: repeat (k % W) v = {v[0], v[W-1:1]};
      default: v = '0;
    endcase
    return {(v == '0), c, v};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("out_stable", 64'({bus.out_zero, bus.out_carry, bus.out_data}), 64'(held));
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_op, bus.in_data, int'(bus.in_shamt)));
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        compared++;
        assert (exp_q.size() != 0) else begin
          mismatched++;
          $error("FAIL unexpected_output: observed=%0h expected=none", bus.out_data);
        end
        if (exp_q.size() != 0)
          check("result", 64'({bus.out_zero, bus.out_carry, bus.out_data}), 64'(exp_q.pop_front()));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = {bus.out_zero, bus.out_carry, bus.out_data};
    end
  end

  task automatic drive(input logic [2:0] op, input logic [W-1:0] d, input int k);
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_shamt = SW'(k);
    bus.in_valid = 1'b1;
  endtask

  task automatic directed(input string tag, input logic [2:0] op, input logic [W-1:0] d, input int k,
                          input logic [W-1:0] ed, input logic ec, input logic ez);
    drive(op, d, k);
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, "_early_valid"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"}, 64'(bus.out_data), 64'(ed));
    check({tag, "_carry"}, 64'(bus.out_carry), 64'(ec));
    check({tag, "_zero"}, 64'(bus.out_zero), 64'(ez));
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    bus.out_ready = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_drained"}, 64'(exp_q.size() == 0 && !bus.out_valid), 64'd1);
  endtask

  initial begin
    int n0;
    int sent;
    int cyc;
    logic acc;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_carry", 64'(bus.out_carry), 64'd0);
    check("rst_out_zero", 64'(bus.out_zero), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    directed("sll23",  3'd0, 24'h000001, 23,  24'h800000, 1'b0, 1'b0);
    directed("sll24",  3'd0, 24'h000001, 24,  24'h000000, 1'b1, 1'b1);
    directed("sll200", 3'd0, 24'h000001, 200, 24'h000000, 1'b0, 1'b1);
    directed("sra4",   3'd2, 24'h800000, 4,   24'hF80000, 1'b0, 1'b0);
    directed("sra30",  3'd2, 24'h800000, 30,  24'hFFFFFF, 1'b1, 1'b0);
    directed("srl30",  3'd1, 24'h800000, 30,  24'h000000, 1'b0, 1'b1);
    directed("ror25",  3'd4, 24'h000001, 25,  24'h800000, 1'b0, 1'b0);
    directed("rol1",   3'd3, 24'h800001, 1,   24'h000003, 1'b0, 1'b0);
    directed("rol48",  3'd3, 24'h123456, 48,  24'h123456, 1'b0, 1'b0);
    n0 = n_out;
    directed("rsvd",   3'd7, 24'hABCDEF, 5,   24'h000000, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rsvd_count", 64'(n_out - n0), 64'd1);

    // back-to-back stream: in_ready never drops, results on consecutive cycles
    n0 = n_out;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(3'd0, W'(i + 1), 1);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (i < 8) check("tput_in_ready", 64'(bus.in_ready), 64'd1);
      check("tput_out_valid", 64'(bus.out_valid), 64'(i >= 2));
      @(posedge clk); #1;
    end
    wait_drain("tput");
    check("tput_count", 64'(n_out - n0), 64'd8);

    // backpressure: two requests fit, the third waits
    n0 = n_out;
    bus.out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive(3'd0, W'(j + 1), 4);
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'(j < 2));
      @(posedge clk); #1;
    end
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_hold", 64'(bus.in_ready), 64'd0);
      check("bp_hold_data", 64'(bus.out_data), 64'h10);
      check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_drain("bp");
    check("bp_count", 64'(n_out - n0), 64'd3);

    // reset with two requests in flight
    bus.out_ready = 1'b0;
    drive(3'd0, 24'h000001, 1);
    @(posedge clk); #1;
    drive(3'd3, 24'h000100, 2);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("mid_valid_before", 64'(bus.out_valid), 64'd1);
    n0 = n_out;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_data", 64'(bus.out_data), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("mid_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("mid_no_stale", 64'(bus.out_valid), 64'd0);
    end
    check("mid_count", 64'(n_out - n0), 64'd0);
    @(posedge clk); #1;

    // random traffic with random stalls, checked by the monitor's model
    sent = 0;
    cyc  = 0;
    acc  = 1'b0;
    while ((sent < 300 || bus.in_valid) && cyc < 5000) begin
      if (!bus.in_valid || acc) begin
        if (sent < 300 && ($urandom % 4) != 0) begin
          if (($urandom % 4) == 0) drive(3'($urandom % 8), W'($urandom), int'($urandom_range(W - 1, W + 1)));
          else drive(3'($urandom % 8), W'($urandom), int'($urandom % 256));
          sent++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom % 3) != 0;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc && sent >= 300) bus.in_valid = 1'b0;
      cyc++;
    end
    check("rand_budget", 64'(cyc < 5000), 64'd1);
    bus.in_valid = 1'b0;
    wait_drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
